// File: rtl/axi_mm_fifo_mm2s.sv
// Drains DRAM ring blocks (valid mask, last mask, data words) to AXI-Stream; data path adds 0 cycles.
// Backpressure: flagged beats hold rready on tready, unflagged beats are always accepted and dropped.
module axi_mm_fifo_mm2s #(
  parameter int C_WIDTH      = 64,
  parameter int C_START_ADDR = 0,
  parameter int C_END_ADDR   = 134217727,
  localparam int AW          = $clog2(C_END_ADDR + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  output logic               busy,
  output logic [AW-1:0]      mem_ptr,
  output logic [AW-1:0]      m_axi_araddr,
  output logic [7:0]         m_axi_arlen,
  output logic               m_axi_arvalid,
  input  logic               m_axi_arready,
  input  logic [C_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]         m_axi_rresp,
  input  logic               m_axi_rlast,
  input  logic               m_axi_rvalid,
  output logic               m_axi_rready,
  output logic               rresp_err,
  output logic [C_WIDTH-1:0] m_axis_tdata,
  output logic               m_axis_tlast,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
);
  localparam int BLK = C_WIDTH * C_WIDTH / 8;
  localparam int LB  = $clog2(BLK);
  localparam int NF  = C_WIDTH - 2;
  localparam int IW  = $clog2(NF);

  localparam logic [AW-1:0] START_A = AW'(C_START_ADDR);
  localparam logic [AW-1:0] END_A   = AW'(C_END_ADDR);
  localparam logic [AW-1:0] BLK_A   = AW'(BLK);
  localparam logic [AW-1:0] DOFS_A  = AW'(2 * (C_WIDTH / 8));

  typedef enum logic [2:0] {
    ST_IDLE, ST_ADDR_H, ST_READ_H, ST_ADDR_D, ST_READ_D
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] mem_ptr_q, mem_ptr_d;
  logic [AW-1:0] araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic          arvalid_q, arvalid_d;
  logic          rresp_err_q, rresp_err_d;
  logic [NF-1:0] flags_valid_q, flags_valid_d;
  logic [NF-1:0] flags_last_q, flags_last_d;
  logic [IW-1:0] idx_q, idx_d;

  logic          ar_hs, r_hs, cur_valid, cur_last;
  logic [AW-1:0] ptr_next;

  assign ar_hs     = arvalid_q & m_axi_arready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign cur_valid = flags_valid_q[idx_q];
  assign cur_last  = flags_last_q[idx_q];
  // The final ring block may not fill the address space, so compare block numbers.
  assign ptr_next  = ((mem_ptr_q >> LB) == (END_A >> LB)) ? START_A : mem_ptr_q + BLK_A;

  assign busy          = (state_q != ST_IDLE);
  assign mem_ptr       = mem_ptr_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign rresp_err     = rresp_err_q;

  always_comb begin
    m_axi_rready  = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_READ_H: m_axi_rready = 1'b1;
      ST_READ_D: begin
        m_axi_rready  = cur_valid ? m_axis_tready : 1'b1;
        m_axis_tvalid = m_axi_rvalid & cur_valid;
        m_axis_tdata  = m_axi_rdata;
        m_axis_tlast  = cur_last;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mem_ptr_d     = mem_ptr_q;
    araddr_d      = araddr_q;
    arlen_d       = arlen_q;
    flags_valid_d = flags_valid_q;
    flags_last_d  = flags_last_q;
    idx_d         = idx_q;
    rresp_err_d   = r_hs & (m_axi_rresp != 2'b00);
    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d  = ST_ADDR_H;
          araddr_d = mem_ptr_q;
          arlen_d  = 8'd1;
          idx_d    = '0;
        end
      end
      ST_ADDR_H: if (ar_hs) state_d = ST_READ_H;
      ST_READ_H: begin
        if (r_hs) begin
          if (idx_q == '0) flags_valid_d = m_axi_rdata[NF-1:0];
          else             flags_last_d  = m_axi_rdata[NF-1:0];
          idx_d = idx_q + IW'(1);
          // Follow rlast even if the header burst is short or long.
          if (m_axi_rlast) begin
            idx_d = '0;
            if (flags_valid_d == '0) begin
              state_d   = ST_IDLE;
              mem_ptr_d = ptr_next;
            end else begin
              state_d  = ST_ADDR_D;
              araddr_d = mem_ptr_q | DOFS_A;
              arlen_d  = 8'(C_WIDTH - 3);
            end
          end
        end
      end
      ST_ADDR_D: if (ar_hs) state_d = ST_READ_D;
      ST_READ_D: begin
        if (r_hs) begin
          idx_d = idx_q + IW'(1);
          if (m_axi_rlast) begin
            state_d   = ST_IDLE;
            mem_ptr_d = ptr_next;
            idx_d     = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arvalid_d = (state_d == ST_ADDR_H) || (state_d == ST_ADDR_D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      mem_ptr_q     <= START_A;
      araddr_q      <= '0;
      arlen_q       <= '0;
      arvalid_q     <= 1'b0;
      rresp_err_q   <= 1'b0;
      flags_valid_q <= '0;
      flags_last_q  <= '0;
      idx_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_ptr_q     <= mem_ptr_d;
      araddr_q      <= araddr_d;
      arlen_q       <= arlen_d;
      arvalid_q     <= arvalid_d;
      rresp_err_q   <= rresp_err_d;
      flags_valid_q <= flags_valid_d;
      flags_last_q  <= flags_last_d;
      idx_q         <= idx_d;
    end
  end
endmodule
